reorder_buf: RTL
================

REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 SHALL have parameters (name, default, meaning): DEPTH, 16, entry count (power of 2, >=4); PREG_W, 7, physical reg tag width; XLEN, 32, data width; IDX_W = log2(DEPTH), derived.
REQ-002 SHALL have ports (name direction width meaning), one clock; reset is asynchronous and active-high:
  clk  in  1  clock
  rst  in  1  async active-high reset
  dc_valid  in  1  dispatch request
  dc_ready  out  1  dispatch accepted when high
  dc_pc, dc_inst  in  XLEN  debug pc / instruction
  dc_prd_new, dc_prd_old  in  PREG_W  new / previous physical rd
  dc_rob_idx  out  IDX_W  index allocated to current dispatch (=tail)
  rr_valid  in  1  issue notice; rr_rob_idx  in  IDX_W; rr_wb_free  in  1  entry needs no writeback
  wb_valid  in  1  writeback; wb_rob_idx  in  IDX_W; wb_data  in  XLEN
  mis_valid  in  1  mispredict; mis_rob_idx  in  IDX_W  mispredicting entry (survives)
  cm_valid  out  2  commit slot valid (bit0 = oldest)
  cm_wb_en  out  2  commit slot has prd_new != 0
  cm_ard  out  2x5; cm_prd_old, cm_prd_new  out  2xPREG_W; cm_pc, cm_data  out  2xXLEN
  rb_valid  out  2  rollback slot valid (bit0 = youngest)
  rb_ard  out  2x5; rb_prd_old, rb_prd_new  out  2xPREG_W
  busy  out  1  recovery in progress
  count  out  IDX_W+1  occupied entries

Function
REQ-003 SHALL keep head, tail (IDX_W, wrap mod DEPTH) and count; empty = count==0, full = count==DEPTH (no head==tail ambiguity).
REQ-004 SHALL define age(i) = (i - head) mod DEPTH; "younger" = larger age.
REQ-005 dc_ready SHALL = !full && state==NORMAL && !mis_valid.
REQ-006 On dc_valid&&dc_ready: entry[tail] gets pc, inst, prd_new, prd_old, ard=inst[11:7], valid=1, issued=0, done=0; tail+1 next cycle.
REQ-007 rr_valid to valid entry SHALL set issued=1 and done=rr_wb_free; wb_valid to valid entry SHALL set done=1, data=wb_data; same-cycle wb wins over rr on same entry; either to invalid entry ignored.
REQ-008 Flush boundary B = mis_rob_idx in cycle mis_valid is accepted, else captured mis_idx_r while RECOVER; entries with age > age(B) are ineligible to commit.
REQ-009 Commit slot0 = head when valid, done, eligible; slot1 = head+1 only if slot0 commits and head+1 valid, done, eligible; committed entries cleared, head advances by commits, combinational outputs.
REQ-010 Two states NORMAL, RECOVER; reset -> NORMAL.
REQ-011 NORMAL, mis_valid on valid entry: mis_idx_r <= mis_rob_idx; go RECOVER unless tail == mis_rob_idx+1 (nothing younger), then stay NORMAL; mis_valid to invalid entry ignored.
REQ-012 RECOVER: rb slot0 = tail-1, slot1 = tail-2, each valid only if entry valid and age > age(mis_idx_r), slot1 only with slot0; rolled entries cleared, tail decremented by rolled count.
REQ-013 RECOVER -> NORMAL in the cycle new tail == mis_idx_r+1; dispatch resumes next cycle.
REQ-014 mis_valid in RECOVER with age(mis_rob_idx) < age(mis_idx_r) SHALL replace mis_idx_r; otherwise ignored.
REQ-015 Commit and rollback in same cycle SHALL both occur; count_next = count + dispatch - commits - rollbacks.
REQ-016 busy SHALL = (state==RECOVER); rollback never touches entries aged <= age(mis_idx_r), mispredicting entry included.
REQ-017 Wrap: all index arithmetic modulo DEPTH, including tail decrement past 0 and head+1 at DEPTH-1.

Reset
REQ-018 rst high SHALL asynchronously clear head, tail, count, all entry valid/issued/done, mis_idx_r, state=NORMAL; outputs: cm_valid=0, rb_valid=0, busy=0, count=0, dc_rob_idx=0, dc_ready=1 after release.
REQ-019 rst mid-RECOVER SHALL abort recovery, no further rb_valid.

Verification
REQ-020 Fill: 16 dispatches, no wb -> count=16, dc_ready=0; wb idx0 -> cm_valid=01 next cycle, dc_ready=1 after commit.
REQ-021 Dual commit: idx0..3 done -> cm_valid=11 two consecutive cycles, head 0->2->4, count 4->0.
REQ-022 Recovery: entries 0..6, mis_valid idx2 -> busy 1; rb idx6,5 then 4,3; tail=3, busy 0, dc_rob_idx=3.
REQ-023 Wrap: head=14, tail=3 (entries 14..2), mis idx15 -> rollback 2,1 then 0; tail=0; idx15 commits when done.
REQ-024 Nested: RECOVER with mis_idx_r=5, mis_valid idx3 -> boundary 3, rollback continues to tail=4; mis_valid idx7 ignored.
REQ-025 Reset mid-RECOVER -> all outputs at reset values next edge; dispatch to idx0 accepted after release.

Source files
------------

// File: rtl/reorder_buf.sv
// Reorder buffer: in-order dispatch, up to two in-order commits per cycle, and
// two-per-cycle tail rollback after a branch mispredict.
module reorder_buf #(
    parameter int  DEPTH  = 16,
    parameter int  PREG_W = 7,
    parameter int  XLEN   = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dc_valid,
    output logic                   dc_ready,
    input  logic [XLEN-1:0]        dc_pc,
    input  logic [XLEN-1:0]        dc_inst,
    input  logic [PREG_W-1:0]      dc_prd_new,
    input  logic [PREG_W-1:0]      dc_prd_old,
    output logic [IDX_W-1:0]       dc_rob_idx,
    input  logic                   rr_valid,
    input  logic [IDX_W-1:0]       rr_rob_idx,
    input  logic                   rr_wb_free,
    input  logic                   wb_valid,
    input  logic [IDX_W-1:0]       wb_rob_idx,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   mis_valid,
    input  logic [IDX_W-1:0]       mis_rob_idx,
    output logic [1:0]             cm_valid,
    output logic [1:0]             cm_wb_en,
    output logic [1:0][4:0]        cm_ard,
    output logic [1:0][PREG_W-1:0] cm_prd_old,
    output logic [1:0][PREG_W-1:0] cm_prd_new,
    output logic [1:0][XLEN-1:0]   cm_pc,
    output logic [1:0][XLEN-1:0]   cm_data,
    output logic [1:0]             rb_valid,
    output logic [1:0][4:0]        rb_ard,
    output logic [1:0][PREG_W-1:0] rb_prd_old,
    output logic [1:0][PREG_W-1:0] rb_prd_new,
    output logic                   busy,
    output logic [IDX_W:0]         count
);

    localparam logic [0:0] S_NORMAL  = 1'b0;
    localparam logic [0:0] S_RECOVER = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, mis_idx_q, mis_idx_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, issued_q, issued_d, done_q, done_d;

    logic [XLEN-1:0]   pc_q      [DEPTH];
    logic [XLEN-1:0]   data_q    [DEPTH];
    logic [4:0]        ard_q     [DEPTH];
    logic [PREG_W-1:0] prd_new_q [DEPTH];
    logic [PREG_W-1:0] prd_old_q [DEPTH];

    function automatic logic [IDX_W-1:0] age_of(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] hd);
        return idx - hd;
    endfunction

    logic             full, recovering, dispatch;
    logic             mis_take_n, mis_take_r, mis_take;
    logic             bound_en, commit_kill, elig1;
    logic             cm0, cm1, rb0, rb1;
    logic [1:0]       n_cm, n_rb;
    logic [IDX_W-1:0] bound, head_p1, tail_m1, tail_m2, mis_p1, mis_q_p1;

    assign full       = (count_q == (IDX_W+1)'(DEPTH));
    assign recovering = (state_q == S_RECOVER);
    assign dc_ready   = !full && !recovering && !mis_valid;
    assign dispatch   = dc_valid && dc_ready;

    assign head_p1  = head_q + 1'b1;
    assign tail_m1  = tail_q - 1'b1;
    assign tail_m2  = tail_q - 2'd2;
    assign mis_p1   = mis_rob_idx + 1'b1;
    assign mis_q_p1 = mis_idx_q + 1'b1;

    // A nested mispredict only matters if it is older than the one being recovered.
    assign mis_take_n = !recovering && mis_valid && valid_q[mis_rob_idx];
    assign mis_take_r = recovering && mis_valid && valid_q[mis_rob_idx] && valid_q[mis_idx_q]
                        && (age_of(mis_rob_idx, head_q) < age_of(mis_idx_q, head_q));
    assign mis_take   = mis_take_n || mis_take_r;

    assign bound    = mis_take ? mis_rob_idx : mis_idx_q;
    assign bound_en = mis_take || recovering;
    // Once the mispredicting entry itself has retired, everything left is wrong-path.
    assign commit_kill = recovering && !valid_q[mis_idx_q] && !mis_take;
    assign elig1 = !bound_en || (age_of(head_p1, head_q) <= age_of(bound, head_q));

    assign cm0 = valid_q[head_q] && done_q[head_q] && !commit_kill;
    assign cm1 = cm0 && valid_q[head_p1] && done_q[head_p1] && elig1;
    assign rb0 = recovering && valid_q[tail_m1] && (tail_m1 != mis_idx_q);
    assign rb1 = rb0 && valid_q[tail_m2] && (tail_m2 != mis_idx_q);

    assign n_cm = {1'b0, cm0} + {1'b0, cm1};
    assign n_rb = {1'b0, rb0} + {1'b0, rb1};

    assign head_d  = head_q + IDX_W'(n_cm);
    assign tail_d  = tail_q + IDX_W'(dispatch) - IDX_W'(n_rb);
    assign count_d = count_q + (IDX_W+1)'(dispatch) - (IDX_W+1)'(n_cm) - (IDX_W+1)'(n_rb);

    always_comb begin
        state_d   = state_q;
        mis_idx_d = mis_idx_q;
        if (mis_take) begin
            mis_idx_d = mis_rob_idx;
        end
        if (!recovering) begin
            if (mis_take_n && (tail_q != mis_p1)) begin
                state_d = S_RECOVER;
            end
        end else if (!mis_take_r && (tail_d == mis_q_p1)) begin
            state_d = S_NORMAL;
        end
    end

    // Writeback is applied after issue so it wins on the same entry; retire and
    // rollback clears come next, and a fresh dispatch is written last.
    always_comb begin
        valid_d  = valid_q;
        issued_d = issued_q;
        done_d   = done_q;
        if (rr_valid && valid_q[rr_rob_idx]) begin
            issued_d[rr_rob_idx] = 1'b1;
            done_d[rr_rob_idx]   = rr_wb_free;
        end
        if (wb_valid && valid_q[wb_rob_idx]) begin
            done_d[wb_rob_idx] = 1'b1;
        end
        if (cm0) begin
            valid_d[head_q] = 1'b0; issued_d[head_q] = 1'b0; done_d[head_q] = 1'b0;
        end
        if (cm1) begin
            valid_d[head_p1] = 1'b0; issued_d[head_p1] = 1'b0; done_d[head_p1] = 1'b0;
        end
        if (rb0) begin
            valid_d[tail_m1] = 1'b0; issued_d[tail_m1] = 1'b0; done_d[tail_m1] = 1'b0;
        end
        if (rb1) begin
            valid_d[tail_m2] = 1'b0; issued_d[tail_m2] = 1'b0; done_d[tail_m2] = 1'b0;
        end
        if (dispatch) begin
            valid_d[tail_q] = 1'b1; issued_d[tail_q] = 1'b0; done_d[tail_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_NORMAL;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            mis_idx_q <= '0;
            valid_q   <= '0;
            issued_q  <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            mis_idx_q <= mis_idx_d;
            valid_q   <= valid_d;
            issued_q  <= issued_d;
            done_q    <= done_d;
        end
    end

    // Payload is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge clk) begin
        if (dispatch) begin
            pc_q[tail_q]      <= dc_pc;
            ard_q[tail_q]     <= dc_inst[11:7];
            prd_new_q[tail_q] <= dc_prd_new;
            prd_old_q[tail_q] <= dc_prd_old;
        end
        if (wb_valid && valid_q[wb_rob_idx]) begin
            data_q[wb_rob_idx] <= wb_data;
        end
    end

    always_comb begin
        cm_valid      = {cm1, cm0};
        cm_wb_en[0]   = cm0 && (prd_new_q[head_q] != '0);
        cm_wb_en[1]   = cm1 && (prd_new_q[head_p1] != '0);
        cm_ard[0]     = ard_q[head_q];
        cm_ard[1]     = ard_q[head_p1];
        cm_prd_old[0] = prd_old_q[head_q];
        cm_prd_old[1] = prd_old_q[head_p1];
        cm_prd_new[0] = prd_new_q[head_q];
        cm_prd_new[1] = prd_new_q[head_p1];
        cm_pc[0]      = pc_q[head_q];
        cm_pc[1]      = pc_q[head_p1];
        cm_data[0]    = data_q[head_q];
        cm_data[1]    = data_q[head_p1];
        rb_valid      = {rb1, rb0};
        rb_ard[0]     = ard_q[tail_m1];
        rb_ard[1]     = ard_q[tail_m2];
        rb_prd_old[0] = prd_old_q[tail_m1];
        rb_prd_old[1] = prd_old_q[tail_m2];
        rb_prd_new[0] = prd_new_q[tail_m1];
        rb_prd_new[1] = prd_new_q[tail_m2];
    end

    assign busy       = recovering;
    assign count      = count_q;
    assign dc_rob_idx = tail_q;

    logic unused_sink;
    assign unused_sink = ^{dc_inst[XLEN-1:12], dc_inst[6:0], issued_q};

endmodule
